// File: rtl/ppu_pkg.sv
// Shared sprite-pipeline constants, attribute bit map and pixel type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_pkg;

  localparam int SLOTS  = 8;
  localparam int XW     = 8;
  localparam int SLOT_W = $clog2(SLOTS);

  // Attribute byte layout as delivered on the fetch bus.
  localparam int PAL_LSB   = 0;
  localparam int PRIO_BIT  = 5;
  localparam int HFLIP_BIT = 6;

  // Sprite pixel presented to the PPU mux: {palette[1:0], pat_h, pat_l}.
  typedef logic [3:0] zcol_t;

  // Mirror a pattern byte for horizontally flipped sprites.
  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: X down-counter, attribute latch and pattern shifters.
// Latency: loads and shifts land on the next PCLK edge; pixel output is combinational.
// Backpressure: none; any load to this slot freezes its pixel advance for that clock.
module sprite_slot #(
  parameter int XW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vis,
  input  logic          ld_x,
  input  logic          ld_attr,
  input  logic          ld_patl,
  input  logic          ld_path,
  input  logic [7:0]    pd,
  output logic [1:0]    pix,
  output logic [1:0]    pal,
  output logic          prio
);
  import ppu_pkg::*;

  logic [XW-1:0] xcnt;
  logic          hflip;
  logic [7:0]    shl;
  logic [7:0]    shh;

  // Loads take precedence over pixel advance; strobes arrive already prioritised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcnt  <= '0;
      pal   <= 2'b00;
      prio  <= 1'b0;
      hflip <= 1'b0;
      shl   <= 8'h00;
      shh   <= 8'h00;
    end else if (ld_x) begin
      xcnt <= XW'(pd);
    end else if (ld_attr) begin
      pal   <= pd[PAL_LSB +: 2];
      prio  <= pd[PRIO_BIT];
      hflip <= pd[HFLIP_BIT];
    end else if (ld_patl) begin
      shl <= hflip ? rev8(pd) : pd;
    end else if (ld_path) begin
      shh <= hflip ? rev8(pd) : pd;
    end else if (vis) begin
      if (xcnt != '0) begin
        xcnt <= xcnt - XW'(1);
      end else begin
        shl <= {shl[6:0], 1'b0};
        shh <= {shh[6:0], 1'b0};
      end
    end
  end

  // Slot is only visible once its X counter has run out.
  always_comb begin
    pix = 2'b00;
    if (xcnt == '0) pix = {shh[7], shl[7]};
  end

endmodule

// File: rtl/sprite_fifo.sv
// Sprite output pipeline: SLOTS slots, lowest-index opaque slot wins. Optional CLIP input under SPR_CLIP_EN.
// Latency: 1 PCLK from the VIS edge exposing a pixel to ZCOL/ZPRIO/SPR0_HIT.
// Backpressure: none; outputs hold while VIS is low.
module sprite_fifo #(
  parameter int SLOTS = ppu_pkg::SLOTS,
  parameter int XW    = ppu_pkg::XW
) (
  input  logic       PCLK,
  input  logic       n_RES,
  input  logic       VIS,
  input  logic [2:0] SLOT,
  input  logic       LD_X,
  input  logic       LD_ATTR,
  input  logic       LD_PATL,
  input  logic       LD_PATH,
  input  logic [7:0] PD,
  input  logic       SPR0_IN,
  output logic [3:0] ZCOL,
  output logic       ZPRIO,
  output logic       SPR0_HIT
`ifdef SPR_CLIP_EN
  ,
  input  logic       CLIP
`endif
);
  import ppu_pkg::*;

  // One strobe per clock wins: X > ATTR > PATL > PATH.
  logic st_x, st_attr, st_patl, st_path;
  assign st_x    = LD_X;
  assign st_attr = LD_ATTR & ~LD_X;
  assign st_patl = LD_PATL & ~LD_X & ~LD_ATTR;
  assign st_path = LD_PATH & ~LD_X & ~LD_ATTR & ~LD_PATL;

  logic [1:0] pix  [SLOTS];
  logic [1:0] pal  [SLOTS];
  logic       prio [SLOTS];
  logic       s0;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic sel;
    assign sel = (SLOT == 3'(i));
    sprite_slot #(.XW(XW)) u_slot (
      .clk     (PCLK),
      .rst_n   (n_RES),
      .vis     (VIS),
      .ld_x    (sel & st_x),
      .ld_attr (sel & st_attr),
      .ld_patl (sel & st_patl),
      .ld_path (sel & st_path),
      .pd      (PD),
      .pix     (pix[i]),
      .pal     (pal[i]),
      .prio    (prio[i])
    );
  end

  // Sprite-0 marker travels with the slot-0 attribute load.
  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) s0 <= 1'b0;
    else if (st_attr && SLOT == 3'd0) s0 <= SPR0_IN;
  end

  // Priority encoder: scan high to low so the lowest opaque index is written last.
  zcol_t win_col;
  logic  win_prio;
  logic  win_hit;
  always_comb begin
    win_col  = '0;
    win_prio = 1'b0;
    win_hit  = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pix[i] != 2'b00) begin
        win_col  = {pal[i], pix[i]};
        win_prio = prio[i];
        win_hit  = (i == 0) && s0;
      end
    end
  end

  logic mask;
`ifdef SPR_CLIP_EN
  assign mask = CLIP;
`else
  assign mask = 1'b0;
`endif

  // Output registers sample pre-shift slot state on each visible pixel.
  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) begin
      ZCOL     <= 4'h0;
      ZPRIO    <= 1'b0;
      SPR0_HIT <= 1'b0;
    end else if (VIS) begin
      ZCOL     <= mask ? 4'h0 : win_col;
      ZPRIO    <= win_prio & ~mask;
      SPR0_HIT <= win_hit & ~mask;
    end
  end

endmodule

// File: tb/tb_sprite_fifo.sv
// Directed bench for sprite_fifo: loads slots, runs visible pixels, compares against hand-computed outputs.
// Latency: one PCLK per visible pixel; outputs sampled 1 time unit after the rising edge.
// Backpressure: none.
module tb_sprite_fifo;

  logic       PCLK = 1'b0;
  logic       n_RES = 1'b0;
  logic       VIS = 1'b0;
  logic [2:0] SLOT = 3'd0;
  logic       LD_X = 1'b0, LD_ATTR = 1'b0, LD_PATL = 1'b0, LD_PATH = 1'b0;
  logic [7:0] PD = 8'h00;
  logic       SPR0_IN = 1'b0;
  logic [3:0] ZCOL;
  logic       ZPRIO;
  logic       SPR0_HIT;
`ifdef SPR_CLIP_EN
  logic       CLIP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  sprite_fifo dut (
    .PCLK     (PCLK),
    .n_RES    (n_RES),
    .VIS      (VIS),
    .SLOT     (SLOT),
    .LD_X     (LD_X),
    .LD_ATTR  (LD_ATTR),
    .LD_PATL  (LD_PATL),
    .LD_PATH  (LD_PATH),
    .PD       (PD),
    .SPR0_IN  (SPR0_IN),
    .ZCOL     (ZCOL),
    .ZPRIO    (ZPRIO),
    .SPR0_HIT (SPR0_HIT)
`ifdef SPR_CLIP_EN
    ,
    .CLIP     (CLIP)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    VIS = 1'b0;
    n_RES = 1'b0;
    #3;
    n_RES = 1'b1;
    tick();
  endtask

  // kind: 0 = X, 1 = ATTR, 2 = PATL, 3 = PATH
  task automatic load(input logic [2:0] s, input int kind, input logic [7:0] d);
    SLOT = s;
    PD = d;
    LD_X    = (kind == 0);
    LD_ATTR = (kind == 1);
    LD_PATL = (kind == 2);
    LD_PATH = (kind == 3);
    tick();
    LD_X = 1'b0; LD_ATTR = 1'b0; LD_PATL = 1'b0; LD_PATH = 1'b0;
  endtask

  task automatic load_slot(input logic [2:0] s, input logic [7:0] x, input logic [7:0] a,
                           input logic [7:0] pl, input logic [7:0] ph);
    load(s, 0, x);
    load(s, 1, a);
    load(s, 2, pl);
    load(s, 3, ph);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ZCOL !== 4'h0 || ZPRIO !== 1'b0 || SPR0_HIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got zcol=%h prio=%b hit=%b, want 0 0 0", ZCOL, ZPRIO, SPR0_HIT);
    end
  endtask

  task automatic test_xdelay();
    do_reset();
    load_slot(3'd0, 8'd3, 8'h01, 8'h80, 8'h00);
    VIS = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (ZCOL !== ((k == 4) ? 4'h5 : 4'h0)) begin
        errors++;
        $display("FAIL xdelay pix%0d: got %h, want %h", k, ZCOL, (k == 4) ? 4'h5 : 4'h0);
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_hflip();
    do_reset();
    load_slot(3'd0, 8'd0, 8'h40, 8'h01, 8'h00);
    VIS = 1'b1;
    tick();
    checks++;
    if (ZCOL !== 4'h1) begin
      errors++;
      $display("FAIL hflip_first: got %h, want 1", ZCOL);
    end
    tick();
    checks++;
    if (ZCOL !== 4'h0) begin
      errors++;
      $display("FAIL hflip_second: got %h, want 0", ZCOL);
    end
    do_reset();
    load_slot(3'd0, 8'd0, 8'h00, 8'h01, 8'h00);
    VIS = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (ZCOL !== ((k == 8) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL noflip pix%0d: got %h, want %h", k, ZCOL, (k == 8) ? 4'h1 : 4'h0);
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_overlap();
    do_reset();
    load_slot(3'd2, 8'd0, 8'h02, 8'hFF, 8'h00);
    load_slot(3'd5, 8'd0, 8'h23, 8'h00, 8'hFF);
    VIS = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (ZCOL !== 4'h9 || ZPRIO !== 1'b0) begin
        errors++;
        $display("FAIL overlap_s2 pix%0d: got %h/%b, want 9/0", k, ZCOL, ZPRIO);
      end
    end
    VIS = 1'b0;
    load(3'd2, 2, 8'h00);
    load(3'd5, 3, 8'hFF);
    VIS = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (ZCOL !== ((k <= 8) ? 4'hE : 4'h0) || ZPRIO !== (k <= 8)) begin
        errors++;
        $display("FAIL overlap_s5 pix%0d: got %h/%b, want %h/%b", k, ZCOL, ZPRIO,
                 (k <= 8) ? 4'hE : 4'h0, (k <= 8));
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_spr0();
    do_reset();
    SPR0_IN = 1'b1;
    load_slot(3'd0, 8'd0, 8'h00, 8'hFF, 8'h00);
    SPR0_IN = 1'b0;
    VIS = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (SPR0_HIT !== (k <= 8)) begin
        errors++;
        $display("FAIL spr0_hit pix%0d: got %b, want %b", k, SPR0_HIT, (k <= 8));
      end
    end
    do_reset();
    SPR0_IN = 1'b0;
    load_slot(3'd0, 8'd0, 8'h00, 8'hFF, 8'h00);
    VIS = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (SPR0_HIT !== 1'b0 || ZCOL !== 4'h1) begin
        errors++;
        $display("FAIL spr0_none pix%0d: got hit=%b zcol=%h, want 0/1", k, SPR0_HIT, ZCOL);
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    load_slot(3'd0, 8'd0, 8'h01, 8'hFF, 8'h00);
    VIS = 1'b1;
    tick();
    VIS = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    VIS = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      checks++;
      if (ZCOL !== ((k <= 8) ? 4'h5 : 4'h0)) begin
        errors++;
        $display("FAIL hold pix%0d: got %h, want %h", k, ZCOL, (k <= 8) ? 4'h5 : 4'h0);
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_load_prio();
    do_reset();
    load_slot(3'd0, 8'd0, 8'h01, 8'hFF, 8'h00);
    SLOT = 3'd0; PD = 8'h02; LD_X = 1'b1; LD_PATL = 1'b1;
    tick();
    LD_X = 1'b0; LD_PATL = 1'b0;
    VIS = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (ZCOL !== ((k == 3) ? 4'h5 : 4'h0)) begin
        errors++;
        $display("FAIL load_prio pix%0d: got %h, want %h", k, ZCOL, (k == 3) ? 4'h5 : 4'h0);
      end
    end
    VIS = 1'b0;
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    load_slot(3'd0, 8'd0, 8'h21, 8'hFF, 8'hFF);
    VIS = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (ZCOL !== 4'h7 || ZPRIO !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got %h/%b, want 7/1", ZCOL, ZPRIO);
    end
    #2;
    n_RES = 1'b0;
    #1;
    checks++;
    if (ZCOL !== 4'h0 || ZPRIO !== 1'b0 || SPR0_HIT !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b, want 0/0/0", ZCOL, ZPRIO, SPR0_HIT);
    end
    @(negedge PCLK);
    n_RES = 1'b1;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (ZCOL !== 4'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_line: got %0d opaque pixels, want 0", bad);
    end
    VIS = 1'b0;
  endtask

`ifdef SPR_CLIP_EN
  task automatic test_clip();
    logic [3:0] want;
    do_reset();
    load_slot(3'd0, 8'd4, 8'h01, 8'hFF, 8'h00);
    VIS = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      CLIP = (k < 8);
      tick();
      want = (k >= 8 && k <= 11) ? 4'h5 : 4'h0;
      checks++;
      if (ZCOL !== want) begin
        errors++;
        $display("FAIL clip pix%0d: got %h, want %h", k, ZCOL, want);
      end
    end
    CLIP = 1'b0;
    VIS = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_xdelay();
    test_hflip();
    test_overlap();
    test_spr0();
    test_hold();
    test_load_prio();
    test_async_reset();
`ifdef SPR_CLIP_EN
    test_clip();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
